// File: rtl/cam_uart_pkg.sv
// Constants and state encodings shared by the camera board UART receive and transmit paths.
// CMD_CHECKSUM_EN selects the 4-byte packet format that carries a checksum byte.
package cam_uart_pkg;

  localparam int         CLKS_PER_BIT  = 1085;
  localparam int         CLKS_PER_BYTE = 11 * CLKS_PER_BIT;
  localparam logic [7:0] HEADER_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } byte_state_e;

  typedef enum logic [1:0] {
    P_HDR,
    P_ADDR,
    P_DATA
`ifdef CMD_CHECKSUM_EN
    , P_SUM
`endif
  } pkt_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop input synchroniser followed by a start/data/stop bit FSM.
// A byte is presented with a one-cycle valid pulse; a low stop bit gives a framing-error pulse instead.
module uart_rx_byte
  import cam_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = cam_uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // NOTE: the synchroniser chain is deliberately left out of reset so it keeps tracking the
  // line; a line already low at reset release then shows no falling edge and goes to RECOVER.
  always_ff @(posedge clk) begin
    rx_meta_q <= rx;
    rx_sync_q <= rx_meta_q;
    rx_prev_q <= rx_sync_q;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_sync_q) state_d = rx_prev_q ? START : RECOVER;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end
      end
      RECOVER: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: turns header/addr/data[/checksum] packets into register-write pulses.
// With CMD_CHECKSUM_EN defined a fourth checksum byte is required and verified.
module uart_cmd_rx
  import cam_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = cam_uart_pkg::CLKS_PER_BIT,
  parameter logic [7:0] HEADER_BYTE  = cam_uart_pkg::HEADER_BYTE,
  parameter int         TIMEOUT_CLKS = 4 * CLKS_PER_BYTE
) (
  input  logic       Clk,
  input  logic       i_Rst_n,
  input  logic       i_RX,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic [7:0] o_Cmd_Addr,
  output logic [7:0] o_Cmd_Data,
  output logic       o_Cmd_Valid,
  output logic       o_Cmd_Error,
  output logic       o_Busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  pkt_state_e  pkt_q, pkt_d;
  logic [7:0]  addr_q, addr_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  data_q, data_d;
`endif
  logic [7:0]  cmd_addr_q, cmd_addr_d;
  logic [7:0]  cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_err_q, cmd_err_d;
  logic [15:0] tmo_q, tmo_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk      (Clk),
    .rst_n    (i_Rst_n),
    .rx       (i_RX),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always_comb begin
    pkt_d       = pkt_q;
    addr_d      = addr_q;
`ifdef CMD_CHECKSUM_EN
    data_d      = data_q;
`endif
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    cmd_err_d   = 1'b0;
    tmo_d       = (rx_valid || pkt_q == P_HDR) ? 16'd0 : tmo_q + 16'd1;

    // A byte landing on the expiry cycle wins, so the timeout branch is only reached without one.
    if (rx_valid) begin
      unique case (pkt_q)
        P_HDR: if (rx_byte == HEADER_BYTE) pkt_d = P_ADDR;
        P_ADDR: begin
          addr_d = rx_byte;
          pkt_d  = P_DATA;
        end
`ifdef CMD_CHECKSUM_EN
        P_DATA: begin
          data_d = rx_byte;
          pkt_d  = P_SUM;
        end
        P_SUM: begin
          pkt_d = P_HDR;
          if (rx_byte == 8'(addr_q + data_q)) begin
            cmd_addr_d  = addr_q;
            cmd_data_d  = data_q;
            cmd_valid_d = 1'b1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
`else
        P_DATA: begin
          cmd_addr_d  = addr_q;
          cmd_data_d  = rx_byte;
          cmd_valid_d = 1'b1;
          pkt_d       = P_HDR;
        end
`endif
        default: pkt_d = P_HDR;
      endcase
    end else if (frame_err || (pkt_q != P_HDR && tmo_q == TMO_LAST)) begin
      cmd_err_d = 1'b1;
      pkt_d     = P_HDR;
    end
  end

  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      pkt_q       <= P_HDR;
      addr_q      <= '0;
`ifdef CMD_CHECKSUM_EN
      data_q      <= '0;
`endif
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      pkt_q       <= pkt_d;
      addr_q      <= addr_d;
`ifdef CMD_CHECKSUM_EN
      data_q      <= data_d;
`endif
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_err_q   <= cmd_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_Byte       = rx_byte;
  assign o_Byte_Valid = rx_valid;
  assign o_Cmd_Addr   = cmd_addr_q;
  assign o_Cmd_Data   = cmd_data_q;
  assign o_Cmd_Valid  = cmd_valid_q;
  assign o_Cmd_Error  = cmd_err_q;
  assign o_Busy       = (pkt_q != P_HDR);

endmodule
